// File: rtl/password_pkg.sv
// password_pkg
// Shared definitions for the password programmer and validator.
//   - prog_state_t : programmer FSM state encoding (also exported on dbgState)
//   - PASSWORD_LEN / DIGIT_W : password geometry
//   - digit_vec_t  : packed password, digit i in bits [4i+3:4i]
//   - put_digit()  : digit-packing helper, returns a word with one slot replaced
// Optional feature macro: PASSWORD_CONFIRM_EN (adds the confirm-pass states).
package password_pkg;

    localparam int PASSWORD_LEN = 4;
    localparam int DIGIT_W      = 4;

    typedef logic [DIGIT_W-1:0]                    digit_t;
    typedef logic [PASSWORD_LEN-1:0][DIGIT_W-1:0]  digit_vec_t;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ENTRY_0   = 4'd1,
        S_ENTRY_1   = 4'd2,
        S_ENTRY_2   = 4'd3,
        S_ENTRY_3   = 4'd4,
`ifdef PASSWORD_CONFIRM_EN
        S_CONFIRM_0 = 4'd5,
        S_CONFIRM_1 = 4'd6,
        S_CONFIRM_2 = 4'd7,
        S_CONFIRM_3 = 4'd8,
`endif
        S_COMMIT    = 4'd9
    } prog_state_t;

    function automatic digit_vec_t put_digit(digit_vec_t word, logic [1:0] slot, digit_t value);
        digit_vec_t result;
        result       = word;
        result[slot] = value;
        return result;
    endfunction

endpackage

// File: rtl/password_digit_file.sv
// password_digit_file
// 4 x 4-bit register file holding the committed password.
//   CLK, RST    : clock, synchronous active-high reset (reloads INIT_PASSWORD)
//   load        : parallel load of all four digits from load_data
//   load_data   : packed new password
//   address     : read address
//   data        : asynchronous read of the digit at address
module password_digit_file
    import password_pkg::*;
#(
    parameter logic [15:0] INIT_PASSWORD = 16'h0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        load,
    input  digit_vec_t  load_data,
    input  logic [1:0]  address,
    output digit_t      data
);

    digit_vec_t mem;

    // Reset has priority over a load on the same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mem <= INIT_PASSWORD;
        end else if (load) begin
            mem <= load_data;
        end
    end

    assign data = mem[address];

endmodule

// File: rtl/password_programmer.sv
// password_programmer
// Writer side of the serial password lock. Collects four digits into a staging
// file, optionally re-checks them in a confirm pass, then commits all four into
// the committed file in a single edge so the validator never sees a partial value.
//   CLK, RST     : clock, synchronous active-high reset
//   startSet     : begin (or restart) programming
//   cancel       : abort programming, committed password unchanged
//   enable/digit : digit strobe and value
//   address/data : validator read port into the committed file (combinational)
//   programming  : high in entry/confirm states
//   setDone      : one-cycle pulse after a successful commit
//   setError     : last attempt failed; held until next startSet or RST
//   dbgState     : current FSM state
// Optional feature macro: PASSWORD_CONFIRM_EN (confirm pass present when defined).
//
// state        | meaning
// S_IDLE       | waiting for startSet, staging held clear
// S_ENTRY_k    | waiting for digit k of the new password
// S_CONFIRM_k  | waiting for digit k of the repeat entry
// S_COMMIT     | new password is committed, setDone pulses, inputs ignored
module password_programmer
    import password_pkg::*;
#(
    parameter logic [15:0] INIT_PASSWORD = 16'h0000,
    parameter int          MAX_DIGIT     = 9
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        startSet,
    input  logic        cancel,
    input  logic        enable,
    input  logic [3:0]  digit,
    input  logic [1:0]  address,
    output logic [3:0]  data,
    output logic        programming,
    output logic        setDone,
    output logic        setError,
    output logic [3:0]  dbgState
);

    localparam digit_t MAX_D = digit_t'(MAX_DIGIT);

    prog_state_t state, state_next;
    digit_vec_t  staging;
    logic        in_entry, in_confirm;
    logic [1:0]  slot;
    logic        stage_wr, stage_clr, err_set, err_clr, commit_load;

    assign in_entry = (state >= S_ENTRY_0) && (state <= S_ENTRY_3);
`ifdef PASSWORD_CONFIRM_EN
    assign in_confirm = (state >= S_CONFIRM_0) && (state <= S_CONFIRM_3);
`else
    assign in_confirm = 1'b0;
`endif

    // Entry states are 1..4 and confirm states 5..8, so in both ranges the
    // digit slot is the low two state bits minus one (mod 4).
    assign slot = state[1:0] - 2'd1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        stage_wr    = 1'b0;
        stage_clr   = 1'b0;
        err_set     = 1'b0;
        err_clr     = 1'b0;
        commit_load = 1'b0;
        case (state)
            S_IDLE: begin
                stage_clr = 1'b1;
                if (startSet) begin
                    state_next = S_ENTRY_0;
                    err_clr    = 1'b1;
                end
            end
            S_ENTRY_0, S_ENTRY_1, S_ENTRY_2, S_ENTRY_3: begin
                if (cancel) begin
                    state_next = S_IDLE;
                    stage_clr  = 1'b1;
                end else if (startSet) begin
                    state_next = S_ENTRY_0;
                    stage_clr  = 1'b1;
                    err_clr    = 1'b1;
                end else if (enable) begin
                    if (digit > MAX_D) begin
                        state_next = S_IDLE;
                        err_set    = 1'b1;
                    end else begin
                        stage_wr = 1'b1;
                        if (state == S_ENTRY_3) begin
`ifdef PASSWORD_CONFIRM_EN
                            state_next = S_CONFIRM_0;
`else
                            state_next  = S_COMMIT;
                            commit_load = 1'b1;
`endif
                        end else begin
                            state_next = prog_state_t'(state + 4'd1);
                        end
                    end
                end
            end
`ifdef PASSWORD_CONFIRM_EN
            S_CONFIRM_0, S_CONFIRM_1, S_CONFIRM_2, S_CONFIRM_3: begin
                if (cancel) begin
                    state_next = S_IDLE;
                    stage_clr  = 1'b1;
                end else if (startSet) begin
                    state_next = S_ENTRY_0;
                    stage_clr  = 1'b1;
                    err_clr    = 1'b1;
                end else if (enable) begin
                    if (digit == staging[slot]) begin
                        if (state == S_CONFIRM_3) begin
                            state_next  = S_COMMIT;
                            commit_load = 1'b1;
                        end else begin
                            state_next = prog_state_t'(state + 4'd1);
                        end
                    end else begin
                        state_next = S_IDLE;
                        err_set    = 1'b1;
                    end
                end
            end
`endif
            S_COMMIT: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        programming = in_entry || in_confirm;
        setDone     = (state == S_COMMIT);
        dbgState    = state;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            staging  <= '0;
            setError <= 1'b0;
        end else begin
            if (stage_clr) begin
                staging <= '0;
            end else if (stage_wr) begin
                staging <= put_digit(staging, slot, digit);
            end
            if (err_clr) begin
                setError <= 1'b0;
            end else if (err_set) begin
                setError <= 1'b1;
            end
        end
    end

    // The load happens on the edge that enters S_COMMIT so the new password is
    // already readable in the setDone cycle. Without the confirm pass the last
    // digit is still on the input, so it is merged into slot 3 here; with the
    // confirm pass it equals staging[3] anyway.
    password_digit_file #(
        .INIT_PASSWORD (INIT_PASSWORD)
    ) u_committed (
        .CLK       (CLK),
        .RST       (RST),
        .load      (commit_load),
        .load_data (put_digit(staging, 2'd3, digit)),
        .address   (address),
        .data      (data)
    );

endmodule

// File: tb/tb_password_programmer.sv
module tb_password_programmer;
    import password_pkg::*;

    localparam logic [15:0] INIT_PW = 16'h4321;
`ifdef PASSWORD_CONFIRM_EN
    localparam bit CONFIRM = 1'b1;
`else
    localparam bit CONFIRM = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       startSet = 1'b0, cancel = 1'b0, enable = 1'b0;
    logic [3:0] digit = '0;
    logic [1:0] address = '0;
    logic [3:0] data, dbgState;
    logic       programming, setDone, setError;

    password_programmer #(.INIT_PASSWORD(INIT_PW), .MAX_DIGIT(9)) dut (
        .CLK(CLK), .RST(RST), .startSet(startSet), .cancel(cancel),
        .enable(enable), .digit(digit), .address(address), .data(data),
        .programming(programming), .setDone(setDone), .setError(setError),
        .dbgState(dbgState)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: a programming session is a list of accepted digits,
    // a pass number (0 = entry, 1 = confirm) and a confirm position.
    bit         m_active, m_pass, m_commit, m_err;
    logic [3:0] m_pw [4];
    logic [3:0] m_buf [$];
    int         m_pos;

    task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_commit();
        for (int i = 0; i < 4; i++) m_pw[i] = m_buf[i];
        m_active = 0;
        m_commit = 1;
    endtask

    task automatic model_step(bit r, bit st, bit cn, bit en, logic [3:0] d);
        if (r) begin
            m_active = 0; m_pass = 0; m_commit = 0; m_err = 0; m_pos = 0;
            m_buf.delete();
            for (int i = 0; i < 4; i++) m_pw[i] = INIT_PW[4*i +: 4];
        end else if (m_commit) begin
            m_commit = 0;
        end else if (!m_active) begin
            if (st) begin
                m_active = 1; m_pass = 0; m_err = 0; m_pos = 0;
                m_buf.delete();
            end
        end else if (cn) begin
            m_active = 0;
        end else if (st) begin
            m_pass = 0; m_err = 0; m_pos = 0;
            m_buf.delete();
        end else if (en) begin
            if (!m_pass) begin
                if (d > 4'd9) begin
                    m_err = 1; m_active = 0;
                end else begin
                    m_buf.push_back(d);
                    if (m_buf.size() == 4) begin
                        if (CONFIRM) begin
                            m_pass = 1; m_pos = 0;
                        end else begin
                            model_commit();
                        end
                    end
                end
            end else begin
                if (d == m_buf[m_pos]) begin
                    m_pos++;
                    if (m_pos == 4) model_commit();
                end else begin
                    m_err = 1; m_active = 0;
                end
            end
        end
    endtask

    task automatic compare_outputs();
        chk("programming", {3'b0, programming}, {3'b0, m_active});
        chk("setDone", {3'b0, setDone}, {3'b0, m_commit});
        chk("setError", {3'b0, setError}, {3'b0, m_err});
        chk("data", data, m_pw[address]);
        if (!m_active && !m_commit) chk("dbgState_idle", dbgState, S_IDLE);
        else chk("dbgState_busy", {3'b0, dbgState != S_IDLE}, 4'd1);
    endtask

    task automatic cycle(bit st, bit cn, bit en, logic [3:0] d, bit r = 0);
        RST = r; startSet = st; cancel = cn; enable = en; digit = d;
        address = 2'($urandom_range(0, 3));
        @(posedge CLK);
        model_step(r, st, cn, en, d);
        #1;
        compare_outputs();
        RST = 0; startSet = 0; cancel = 0; enable = 0; digit = '0;
    endtask

    task automatic check_all_data(string tag);
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1;
            chk(tag, data, m_pw[a]);
        end
    endtask

    task automatic send_digits(logic [15:0] pw);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, pw[4*i +: 4]);
    endtask

    task automatic program_pw(logic [15:0] pw);
        cycle(1, 0, 0, 4'd0);
        send_digits(pw);
        if (CONFIRM) send_digits(pw);
        cycle(0, 0, 0, 4'd0);
    endtask

    initial begin
        int r;
        bit st, cn, en, rs;
        logic [3:0] d;

        // Reset
        cycle(0, 0, 0, 4'd0, 1);
        cycle(0, 0, 0, 4'd0, 1);
        check_all_data("reset_data");
        chk("reset_prog", {3'b0, programming}, 4'd0);

        // enable in idle is ignored
        cycle(0, 0, 1, 4'd7);

        // Full program 5,6,7,8 (bytes: digit0 in low nibble)
        program_pw(16'h8765);
        check_all_data("commit_5678");

`ifdef PASSWORD_CONFIRM_EN
        // Confirm mismatch 5,6,0,8
        cycle(1, 0, 0, 4'd0);
        send_digits(16'h8765);
        send_digits(16'h8065);
        cycle(0, 0, 0, 4'd0);
        check_all_data("mismatch_keep");
`endif

        // Out-of-range digit C, then boundary A
        cycle(1, 0, 0, 4'd0);
        cycle(0, 0, 1, 4'hC);
        cycle(0, 0, 0, 4'd0);
        cycle(1, 0, 0, 4'd0);
        cycle(0, 0, 1, 4'd3);
        cycle(0, 0, 1, 4'hA);
        check_all_data("range_keep");

        // Cancel with simultaneous enable
        cycle(1, 0, 0, 4'd0);
        cycle(0, 0, 1, 4'd1);
        cycle(0, 0, 1, 4'd2);
        cycle(0, 1, 1, 4'd3);
        cycle(0, 0, 0, 4'd0);
        check_all_data("cancel_keep");

        // Restart mid-entry, then 9999 (max legal digit)
        cycle(1, 0, 0, 4'd0);
        cycle(0, 0, 1, 4'd4);
        program_pw(16'h9999);
        check_all_data("commit_9999");

        // Reset on the final strobe: reset wins over commit
        cycle(1, 0, 0, 4'd0);
        send_digits(16'h1357);
        if (CONFIRM) begin
            for (int i = 0; i < 3; i++) cycle(0, 0, 1, 4'(16'h1357 >> (4*i)));
        end else begin
            cycle(1, 0, 0, 4'd0);
            for (int i = 0; i < 3; i++) cycle(0, 0, 1, 4'(16'h1357 >> (4*i)));
        end
        cycle(0, 0, 1, 4'd1, 1);
        cycle(0, 0, 0, 4'd0);
        check_all_data("reset_wins");

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            r  = int'($urandom_range(0, 199));
            rs = (r == 0);
            st = (r >= 1 && r <= 10);
            cn = (r >= 11 && r <= 14);
            en = ($urandom_range(0, 1) == 1);
            if (m_active && m_pass && m_pos < 4 && $urandom_range(0, 99) < 85)
                d = m_buf[m_pos];
            else
                d = 4'($urandom_range(0, 10));
            cycle(st, cn, en, d, rs);
            if (n % 75 == 74) check_all_data("random_data");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
